// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes (common with the ALU-control decoder),
// execute-stage FSM states and the datapath width.
package alu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_SLL  = 4'b0100,
        OP_SLT  = 4'b0101,
        OP_XOR  = 4'b0110,
        OP_SRL  = 4'b0111,
        OP_SLTU = 4'b1000,
        OP_SRA  = 4'b1111
    } alu_op_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } exec_state_t;

    function automatic logic is_shift_op(input logic [3:0] code);
        return (code == OP_SLL) || (code == OP_SRL) || (code == OP_SRA);
    endfunction

endpackage

// File: rtl/iter_exec_unit_if.sv
// Upstream/downstream handshake bundle for the execute unit.
// master = pipeline side driving ops and consuming results; slave = execute unit.
interface iter_exec_unit_if;

    logic                      flush;
    logic                      in_valid;
    logic                      in_ready;
    logic [3:0]                alu_ctrl;
    logic [alu_pkg::XLEN-1:0]  src_a;
    logic [alu_pkg::XLEN-1:0]  src_b;
    logic [4:0]                rd_in;
    logic                      out_valid;
    logic                      out_ready;
    logic [alu_pkg::XLEN-1:0]  result;
    logic                      zero;
    logic [4:0]                rd_out;

    modport master (
        output flush, in_valid, alu_ctrl, src_a, src_b, rd_in, out_ready,
        input  in_ready, out_valid, result, zero, rd_out
    );

    modport slave (
        input  flush, in_valid, alu_ctrl, src_a, src_b, rd_in, out_ready,
        output in_ready, out_valid, result, zero, rd_out
    );

endinterface

// File: rtl/alu_comb.sv
// Combinational ALU: single-cycle ops, plus a one-bit shift step used by the
// iterative shifter. Shift codes return src_a unchanged here, which is exactly
// the shamt==0 result the top relies on.
import alu_pkg::*;

module alu_comb #(
    parameter int XLEN = alu_pkg::XLEN
) (
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic [XLEN-1:0] res,
    input  logic [3:0]      step_op,
    input  logic [XLEN-1:0] step_in,
    output logic [XLEN-1:0] step_out
);

    // one-cycle operation result
    always_comb begin
        res = '0;
        case (alu_ctrl)
            OP_ADD:  res = src_a + src_b;
            OP_SUB:  res = src_a - src_b;
            OP_AND:  res = src_a & src_b;
            OP_OR:   res = src_a | src_b;
            OP_XOR:  res = src_a ^ src_b;
            OP_SLT:  res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_SLTU: res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            OP_SLL, OP_SRL, OP_SRA: res = src_a;
            default: res = '0;
        endcase
    end

    // single-bit shift step for the iterative path
    always_comb begin
        step_out = step_in;
        case (step_op)
            OP_SLL:  step_out = {step_in[XLEN-2:0], 1'b0};
            OP_SRL:  step_out = {1'b0, step_in[XLEN-1:1]};
            OP_SRA:  step_out = {step_in[XLEN-1], step_in[XLEN-1:1]};
            default: step_out = step_in;
        endcase
    end

endmodule

// File: rtl/iter_exec_unit.sv
// Execute stage: one-cycle ALU ops, iterative 1-bit-per-cycle shifts,
// valid/ready on both sides and flush for mispredict squash.
//
//   state | meaning
//   IDLE  | ready for a new op (if output slot free/draining)
//   SHIFT | shifting work one bit per edge, cnt edges remain
import alu_pkg::*;

module iter_exec_unit #(
    parameter int XLEN    = alu_pkg::XLEN,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    iter_exec_unit_if.slave bus
);

    exec_state_t         state;
    logic [SHAMT_W-1:0]  cnt;
    logic [XLEN-1:0]     work;
    logic [3:0]          op_q;
    logic [4:0]          rd_q;

    logic [XLEN-1:0]     comb_res;
    logic [XLEN-1:0]     step_res;
    logic [SHAMT_W-1:0]  shamt;
    logic                accept;

    alu_comb #(.XLEN(XLEN)) u_alu (
        .alu_ctrl (bus.alu_ctrl),
        .src_a    (bus.src_a),
        .src_b    (bus.src_b),
        .res      (comb_res),
        .step_op  (op_q),
        .step_in  (work),
        .step_out (step_res)
    );

    // ready depends only on state, output slot and flush, never on in_valid
    always_comb begin
        bus.in_ready = (state == IDLE) && (!bus.out_valid || bus.out_ready) && !bus.flush;
        shamt        = bus.src_b[SHAMT_W-1:0];
        accept       = bus.in_valid && bus.in_ready;
    end

    // FSM, shift counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            work          <= '0;
            op_q          <= '0;
            rd_q          <= '0;
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.zero      <= 1'b0;
            bus.rd_out    <= '0;
        end else if (bus.flush) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.out_valid && bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                    end
                    if (accept) begin
                        if (is_shift_op(bus.alu_ctrl) && (shamt != '0)) begin
                            work  <= bus.src_a;
                            cnt   <= shamt;
                            op_q  <= bus.alu_ctrl;
                            rd_q  <= bus.rd_in;
                            state <= SHIFT;
                        end else begin
                            bus.result    <= comb_res;
                            bus.zero      <= (comb_res == '0);
                            bus.rd_out    <= bus.rd_in;
                            bus.out_valid <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    work <= step_res;
                    cnt  <= cnt - SHAMT_W'(1);
                    if (cnt == SHAMT_W'(1)) begin
                        bus.result    <= step_res;
                        bus.zero      <= (step_res == '0);
                        bus.rd_out    <= rd_q;
                        bus.out_valid <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
